// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_if
// Description : Start/done handshake bundle between the ALU sequencer and the
//               8-bit ALU datapath.
//   alu_start : one-cycle start pulse (sequencer -> ALU)
//   alu_op    : latched opcode        (sequencer -> ALU)
//   alu_a     : operand A             (sequencer -> ALU)
//   alu_b     : operand B             (sequencer -> ALU)
//   alu_done  : result valid strobe   (ALU -> sequencer)
//   alu_y     : result                (ALU -> sequencer)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
  logic       alu_start;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_done;
  logic [7:0] alu_y;

  modport master (
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_done, alu_y
  );

  modport slave (
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_done, alu_y
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Debounces the send-operation button, latches the opcode on a
//               clean press and sequences the ALU via a start/done handshake.
//               Owns operand registers A/B and the result register Y.
// Ports       : clock, reset (async, active high), tick (sample strobe),
//               btn_go (raw button), opcode[3:0], data_in[7:0],
//               alu (handshake bundle, master side), reg_a, reg_b, result,
//               busy, error (sticky timeout flag).
// Options     : define ALU_SEQ_FLAGS_EN to add flag_z / flag_n outputs that
//               track the last ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        tick,
  input  wire logic        btn_go,
  input  wire logic [3:0]  opcode,
  input  wire logic [7:0]  data_in,
  alu_sequencer_if.master  alu,
  output logic [7:0]       reg_a,
  output logic [7:0]       reg_b,
  output logic [7:0]       result,
  output logic             busy,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             flag_z,
  output logic             flag_n,
`endif
  output logic             error
);

  localparam int c_DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_db_level;
  logic              r_db_prev;
  logic [c_DB_W-1:0] r_db_cnt;
  logic [c_TO_W-1:0] r_wait_cnt;
  logic [3:0]        r_op;
  logic              w_press;
  logic              w_accept;
  logic              w_done;
  logic              w_timeout;

  // Synchronizer and tick-sampled debouncer. The counter only runs while the
  // synced level disagrees with the debounced level; reaching the last count
  // means DEBOUNCE_TICKS consecutive disagreeing samples, so flip the level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1   <= btn_go;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      if (tick) begin
        if (r_sync2 != r_db_level) begin
          if (r_db_cnt == c_DB_LAST) begin
            r_db_level <= ~r_db_level;
            r_db_cnt   <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end else begin
          r_db_cnt <= '0;
        end
      end
    end
  end

  assign w_press = r_db_level & ~r_db_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Presses outside IDLE fall through here and are simply lost.
        if (w_press) begin
          w_accept    = 1'b1;
          w_state_nxt = (opcode >= 4'd13) ? S_EXEC : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // done is tested first so it wins over a simultaneous expiry
        if (alu.alu_done) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == c_TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op       <= 4'd0;
      r_wait_cnt <= '0;
      reg_a      <= 8'd0;
      reg_b      <= 8'd0;
      result     <= 8'd0;
      error      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= opcode;
        error <= 1'b0;
      end
      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                   r_wait_cnt <= '0;
      if (w_done)    result <= alu.alu_y;
      if (w_timeout) error  <= 1'b1;
      if (r_state == S_EXEC) begin
        case (r_op)
          4'd13: reg_a <= result;
          4'd14: begin
            reg_a <= reg_b;
            reg_b <= reg_a;
          end
          4'd15: reg_a <= data_in;
          default: ;
        endcase
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (w_done) begin
      flag_z <= (alu.alu_y == 8'd0);
      flag_n <= alu.alu_y[7];
    end
  end
`endif

  // Outputs decoded from the state register so reset clears them at once.
  assign busy          = (r_state != S_IDLE);
  assign alu.alu_start = (r_state == S_ISSUE);
  assign alu.alu_op    = r_op;
  assign alu.alu_a     = reg_a;
  assign alu.alu_b     = reg_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
  logic       clock;
  logic       reset;
  logic       tick;
  logic       btn_go;
  logic [3:0] opcode;
  logic [7:0] data_in;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic [7:0] result;
  logic       busy;
  logic       error;
`ifdef ALU_SEQ_FLAGS_EN
  logic       flag_z;
  logic       flag_n;
`endif

  alu_sequencer_if alu_if ();

  alu_sequencer #(
    .DEBOUNCE_TICKS(4),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .btn_go  (btn_go),
    .opcode  (opcode),
    .data_in (data_in),
    .alu     (alu_if),
    .reg_a   (reg_a),
    .reg_b   (reg_b),
    .result  (result),
    .busy    (busy),
`ifdef ALU_SEQ_FLAGS_EN
    .flag_z  (flag_z),
    .flag_n  (flag_n),
`endif
    .error   (error)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int rise_cnt = 0;
  logic busy_q = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    start_cnt <= start_cnt + int'(alu_if.alu_start);
    if (busy && !busy_q) rise_cnt <= rise_cnt + 1;
    busy_q <= busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    while (!busy && k < 40) begin
      cyc(1);
      k++;
    end
    if (!busy) begin
      checks++;
      errors++;
      $error("FAIL %s: busy never rose in 40 cycles, observed 0 expected 1", tag);
    end
  endtask

  task automatic press(input logic [3:0] op, input logic [7:0] d, input string tag);
    opcode  = op;
    data_in = d;
    btn_go  = 1'b1;
    wait_busy(tag);
  endtask

  task automatic release_btn();
    btn_go = 1'b0;
    cyc(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int r0;
    int k_end;

    reset   = 1'b1;
    tick    = 1'b1;
    btn_go  = 1'b0;
    opcode  = 4'd0;
    data_in = 8'd0;
    alu_if.alu_done = 1'b0;
    alu_if.alu_y    = 8'd0;
    cyc(3);
    chk("rst_busy",   busy, 0);
    chk("rst_start",  alu_if.alu_start, 0);
    chk("rst_reg_a",  reg_a, 0);
    chk("rst_reg_b",  reg_b, 0);
    chk("rst_result", result, 0);
    chk("rst_error",  error, 0);
    chk("rst_alu_op", alu_if.alu_op, 0);
    reset = 1'b0;
    cyc(3);

    // Load A with 0x5A
    s0 = start_cnt;
    press(4'hF, 8'h5A, "load");
    chk("load_busy", busy, 1);
    chk("load_start", alu_if.alu_start, 0);
    cyc(1);
    chk("load_busy_1cyc", busy, 0);
    chk("load_reg_a", reg_a, 8'h5A);
    release_btn();
    chk("load_no_start", start_cnt - s0, 0);

    // A=3, swap, A=4, then add
    press(4'hF, 8'h03, "load3"); cyc(1); release_btn();
    press(4'hE, 8'h00, "swap");  cyc(1);
    chk("swap_reg_a", reg_a, 8'h00);
    chk("swap_reg_b", reg_b, 8'h03);
    release_btn();
    press(4'hF, 8'h04, "load4"); cyc(1); release_btn();
    chk("load4_reg_a", reg_a, 8'h04);
    s0 = start_cnt;
    press(4'h0, 8'h00, "add");
    chk("add_start", alu_if.alu_start, 1);
    chk("add_alu_op", alu_if.alu_op, 4'h0);
    chk("add_alu_a", alu_if.alu_a, 8'h04);
    chk("add_alu_b", alu_if.alu_b, 8'h03);
    cyc(1);
    chk("add_start_1cyc", alu_if.alu_start, 0);
    cyc(2);
    chk("add_busy_wait", busy, 1);
    alu_if.alu_done = 1'b1;
    alu_if.alu_y    = 8'h07;
    cyc(1);
    alu_if.alu_done = 1'b0;
    chk("add_busy_fall", busy, 0);
    chk("add_result", result, 8'h07);
    chk("add_error", error, 0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("add_flag_z", flag_z, 0);
    chk("add_flag_n", flag_n, 0);
`endif
    release_btn();
    chk("add_one_start", start_cnt - s0, 1);

    // Bouncing button: toggling every tick must not produce a press
    opcode  = 4'hF;
    data_in = 8'hC3;
    r0 = rise_cnt;
    for (int i = 0; i < 10; i++) begin
      btn_go = ~btn_go;
      cyc(1);
    end
    cyc(1);
    chk("bounce_none", rise_cnt - r0, 0);
    btn_go = 1'b1;
    cyc(20);
    chk("bounce_one", rise_cnt - r0, 1);
    chk("bounce_reg_a", reg_a, 8'hC3);
    release_btn();

    // Second press during WAIT is dropped; the ALU never answers -> timeout
    s0 = start_cnt;
    r0 = rise_cnt;
    k_end = 0;
    press(4'h0, 8'h00, "drop");
    btn_go = 1'b0;
    opcode = 4'h5;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      if (k == 3) begin
        chk("drop_alu_op", alu_if.alu_op, 4'h0);
        chk("drop_error_pre", error, 0);
      end
      if (k == 7) btn_go = 1'b1;
      if (!busy) begin
        k_end = k;
        break;
      end
    end
    chk("timeout_len", k_end, 16);
    chk("timeout_error", error, 1);
    chk("timeout_result", result, 8'h07);
    cyc(3);
    chk("drop_one_start", start_cnt - s0, 1);
    chk("drop_one_accept", rise_cnt - r0, 1);
    release_btn();

    // Next accepted press clears error; 1101 copies result into A
    press(4'hD, 8'h00, "clr");
    chk("clr_error", error, 0);
    cyc(1);
    chk("copy_reg_a", reg_a, 8'h07);
    release_btn();

    // Asynchronous reset during WAIT
    press(4'h0, 8'h00, "rst_op");
    btn_go = 1'b0;
    cyc(2);
    chk("rstop_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy",   busy, 0);
    chk("arst_start",  alu_if.alu_start, 0);
    chk("arst_reg_a",  reg_a, 0);
    chk("arst_reg_b",  reg_b, 0);
    chk("arst_result", result, 0);
    chk("arst_error",  error, 0);
    chk("arst_alu_op", alu_if.alu_op, 0);
    @(negedge clock);
    reset = 1'b0;
    cyc(1);
    s0 = start_cnt;
    alu_if.alu_done = 1'b1;
    alu_if.alu_y    = 8'hEE;
    cyc(1);
    alu_if.alu_done = 1'b0;
    cyc(3);
    chk("post_rst_result", result, 8'h00);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_start", start_cnt - s0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
